// File: rtl/ds_capture_fifo.sv
// Downsampled {x,y} capture FIFO with arm/trigger/length control and overflow accounting.
// Optional per-entry ce_down timestamp when UC_CAPTURE_TSTAMP_EN is defined.
module ds_capture_fifo #(
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  ce_down,
  input  logic signed [DW-1:0]  ds_x,
  input  logic signed [DW-1:0]  ds_y,
  input  logic                  arm,
  input  logic                  stop,
  input  logic                  trig_en,
  input  logic [DEPTH_LOG2:0]   capture_len,
  input  logic                  clr_flags,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic signed [DW-1:0]  rd_x,
  output logic signed [DW-1:0]  rd_y,
  output logic [31:0]           rd_tstamp,
  output logic [DEPTH_LOG2:0]   level,
  output logic [1:0]            state,
  output logic                  overflow,
  output logic [15:0]           drop_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
`ifdef UC_CAPTURE_TSTAMP_EN
  localparam int MW = 2*DW + 32;
`else
  localparam int MW = 2*DW;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level, r_cnt, r_len;
  logic [DW-1:0]         r_prev_x;
  logic                  r_ovf;
  logic [15:0]           r_drop;
  logic                  r_rd_valid;
  logic [MW-1:0]         r_rd_data;
  logic [MW-1:0]         r_mem [DEPTH];

  logic                  w_arm, w_full, w_empty, w_zc, w_try, w_wr, w_drop, w_rd, w_last;
  logic [DEPTH_LOG2:0]   w_cnt_nxt;
  logic [MW-1:0]         w_wdata;

  // stop dominates arm: a simultaneous arm+stop neither flushes nor re-arms
  assign w_arm     = arm & ~stop;
  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_zc      = r_prev_x[DW-1] & ~ds_x[DW-1];
  assign w_try     = ~arm & ~stop & ce_down &
                     (((r_state == S_ARMED) & (~trig_en | w_zc)) | (r_state == S_CAPT));
  assign w_wr      = w_try & ~w_full;
  assign w_drop    = w_try & w_full;
  assign w_rd      = rd_en & ~w_empty & ~w_arm;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (r_len != '0) && (w_cnt_nxt == r_len);

`ifdef UC_CAPTURE_TSTAMP_EN
  logic [31:0] r_ts;
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)          r_ts <= '0;
    else if (w_arm)   r_ts <= '0;
    else if (ce_down) r_ts <= r_ts + 1'b1;
  end
  assign w_wdata   = {r_ts, ds_y, ds_x};
  assign rd_tstamp = r_rd_data[MW-1 -: 32];
`else
  assign w_wdata   = {ds_y, ds_x};
  assign rd_tstamp = '0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else if (stop) begin
      r_state <= S_IDLE;
    end else if (arm) begin
      r_state <= S_ARMED;
      r_cnt   <= '0;
      r_len   <= capture_len;
    end else if (w_try) begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_last ? S_DONE : S_CAPT;
    end
  end

  // Occupancy is tracked separately from the pointers so full/empty never alias.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_arm) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Trigger history restarts at zero on arm, so the first post-arm sample cannot trigger.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)          r_prev_x <= '0;
    else if (w_arm)   r_prev_x <= '0;
    else if (ce_down) r_prev_x <= ds_x;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (clr_flags) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wptr] <= w_wdata;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= r_mem[r_rptr];
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_x       = r_rd_data[DW-1:0];
  assign rd_y       = r_rd_data[2*DW-1:DW];
  assign level      = r_level;
  assign state      = r_state;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
endmodule

// File: tb/tb_ds_capture_fifo.sv
// Directed bench for ds_capture_fifo (depth 4) with a queue scoreboard of expected pops.
module tb_ds_capture_fifo;
  localparam int DW = 16;
  localparam int DL = 2;

  logic          sys_clk, rst, ce_down, arm, stop, trig_en, clr_flags, rd_en;
  logic [DW-1:0] ds_x, ds_y, rd_x, rd_y;
  logic [DL:0]   capture_len, level;
  logic          rd_valid, overflow;
  logic [31:0]   rd_tstamp;
  logic [1:0]    state;
  logic [15:0]   drop_count;

  ds_capture_fifo #(.DW(DW), .DEPTH_LOG2(DL)) dut (
    .sys_clk(sys_clk), .rst(rst), .ce_down(ce_down), .ds_x(ds_x), .ds_y(ds_y),
    .arm(arm), .stop(stop), .trig_en(trig_en), .capture_len(capture_len),
    .clr_flags(clr_flags), .rd_en(rd_en), .rd_valid(rd_valid), .rd_x(rd_x),
    .rd_y(rd_y), .rd_tstamp(rd_tstamp), .level(level), .state(state),
    .overflow(overflow), .drop_count(drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] ts;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ts_m;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input bit exp_v);
    ent_t e;
    chk({tag, "_vld"}, {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL %s: scoreboard empty, got x=%0h", tag, rd_x);
      end else begin
        e = q.pop_front();
        chk({tag, "_x"}, {16'd0, rd_x}, {16'd0, e.x});
        chk({tag, "_y"}, {16'd0, rd_y}, {16'd0, e.y});
        chk({tag, "_ts"}, rd_tstamp, e.ts);
      end
    end
  endtask

  // one ce_down; exp_wr says whether the model expects it to land in the FIFO
  task automatic strobe(input string tag, input logic [15:0] x, input bit exp_wr, input bit rd);
    ent_t e;
    ce_down = 1'b1;
    ds_x    = x;
    ds_y    = x ^ 16'h5A5A;
    rd_en   = rd;
    if (exp_wr) begin
      e.x = x;
      e.y = x ^ 16'h5A5A;
`ifdef UC_CAPTURE_TSTAMP_EN
      e.ts = ts_m;
`else
      e.ts = 32'd0;
`endif
      q.push_back(e);
    end
    tick();
    ce_down = 1'b0;
    rd_en   = 1'b0;
    ts_m    = ts_m + 1;
    if (rd) check_pop(tag, 1'b1);
  endtask

  task automatic rd(input string tag, input bit exp_v);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_pop(tag, exp_v);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    ts_m = 0;
  endtask

  initial begin
    rst = 1'b1; ce_down = 0; arm = 0; stop = 0; trig_en = 0; clr_flags = 0; rd_en = 0;
    ds_x = '0; ds_y = '0; capture_len = '0; ts_m = 0;
    repeat (2) tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_vld", {31'd0, rd_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    tick();

    // length-limited capture, no trigger
    capture_len = 3'd4;
    do_arm();
    chk("len_armed", {30'd0, state}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      strobe("len_wr", 16'(i), i <= 4, 1'b0);
      if (i == 3) chk("len_capt", {30'd0, state}, 32'd2);
      if (i == 4) chk("len_done", {30'd0, state}, 32'd3);
    end
    chk("len_level", {29'd0, level}, 32'd4);
    chk("len_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) rd("len_rd", 1'b1);
    rd("len_empty", 1'b0);
    chk("len_hold_x", {16'd0, rd_x}, 32'd4);
    chk("len_level0", {29'd0, level}, 32'd0);

    // rising zero-crossing trigger
    trig_en = 1'b1;
    capture_len = '0;
    do_arm();
    strobe("trg_m3", 16'hFFFD, 1'b0, 1'b0);
    strobe("trg_m1", 16'hFFFF, 1'b0, 1'b0);
    chk("trg_wait", {30'd0, state}, 32'd1);
    strobe("trg_p2", 16'd2, 1'b1, 1'b0);
    chk("trg_capt", {30'd0, state}, 32'd2);
    strobe("trg_p5", 16'd5, 1'b1, 1'b0);
    rd("trg_rd0", 1'b1);
    rd("trg_rd1", 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("trg_stop", {30'd0, state}, 32'd0);
    trig_en = 1'b0;

    // overflow and flag handling, continuous mode
    do_arm();
    for (int i = 0; i < 6; i++) strobe("ovf_wr", 16'(10 + i), i < 4, 1'b0);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drop2", {16'd0, drop_count}, 32'd2);
    strobe("ovf_wr_rd", 16'd99, 1'b0, 1'b1);
    chk("ovf_drop3", {16'd0, drop_count}, 32'd3);
    chk("ovf_level3", {29'd0, level}, 32'd3);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_drop", {16'd0, drop_count}, 32'd0);
    strobe("ovf_fill", 16'd16, 1'b1, 1'b0);
    clr_flags = 1'b1;
    strobe("clr_vs_drop", 16'd17, 1'b0, 1'b0);
    clr_flags = 1'b0;
    chk("clrwin_ovf", {31'd0, overflow}, 32'd0);
    chk("clrwin_drop", {16'd0, drop_count}, 32'd0);
    chk("clrwin_level", {29'd0, level}, 32'd4);
    for (int i = 0; i < 4; i++) rd("ovf_rd", 1'b1);
    rd("ovf_empty", 1'b0);

    // interleaved write + read every cycle
    for (int i = 0; i < 100; i++) begin
      strobe("ilv", 16'(200 + i), 1'b1, i > 0);
      chk("ilv_level", {29'd0, level}, 32'd1);
    end
    rd("ilv_last", 1'b1);
    chk("ilv_level0", {29'd0, level}, 32'd0);
    chk("ilv_ovf", {31'd0, overflow}, 32'd0);

    // arm+stop together: stop wins, contents kept
    for (int i = 0; i < 3; i++) strobe("as_wr", 16'(300 + i), 1'b1, 1'b0);
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    chk("as_state", {30'd0, state}, 32'd0);
    chk("as_level", {29'd0, level}, 32'd3);
    do_arm();
    q.delete();
    chk("as_rearm_state", {30'd0, state}, 32'd1);
    chk("as_rearm_level", {29'd0, level}, 32'd0);

    // reset mid-capture
    for (int i = 0; i < 3; i++) strobe("rm_wr", 16'(400 + i), 1'b1, 1'b0);
    chk("rm_capt", {30'd0, state}, 32'd2);
    rd("rm_rd", 1'b1);
    rst = 1'b1;
    tick();
    chk("rm_state", {30'd0, state}, 32'd0);
    chk("rm_level", {29'd0, level}, 32'd0);
    chk("rm_vld", {31'd0, rd_valid}, 32'd0);
    chk("rm_x", {16'd0, rd_x}, 32'd0);
    chk("rm_y", {16'd0, rd_y}, 32'd0);
    chk("rm_ts", rd_tstamp, 32'd0);
    rst = 1'b0;
    q.delete();
    tick();
    rd("rm_after", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
